mem2_stage: RTL
===============

# mem2_stage

Second memory stage of the in-order RISC-V pipeline, between MEM1 and WB. Holds the MEM1→MEM2 pipeline register, captures the data-SRAM read response that arrives one cycle after MEM1 issues a load, and aligns and extends it by load type. It produces the `mem22wb_bus` consumed by WB and a bypass bus for operand forwarding. A one-entry hold buffer keeps the SRAM response valid across pipeline stalls.

## Interface
- `MEM12MEM2_WD`, 108: input bus width. Fields, MSB→LSB:
  - `rf_we`[1], `rf_waddr`[5], `rf_wdata`[32], `load_en`[1], `load_type`[3] (funct3), `addr_lo`[2], `pc`[32], `inst`[32].
- `MEM22WB_WD`, 102: output bus width. Fields, MSB→LSB:
  - `rf_we`[1], `rf_waddr`[5], `rf_wdata`[32], `pc`[32], `inst`[32].
- `BYPASS_WD`, 38: bypass width. Fields: `rf_we`[1], `rf_waddr`[5], `rf_wdata`[32].

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `stall` in `StallBus`: pipeline stall vector. Bit 5 holds this stage; bit 6 holds WB.
- `mem12mem2_bus` in `MEM12MEM2_WD`: from MEM1.
- `data_sram_rdata` in 32: SRAM read data, valid only in the first cycle a load occupies this stage.
- `mem22wb_bus` out `MEM22WB_WD`: to WB.
- `mem22bp_bus` out `BYPASS_WD`: forwarding to ID.

## Operation
- **Pipeline register `r`**, updated on the clk edge, in priority order:
  - `!rst_n` → 0.
  - `stall[5] & !stall[6]` → 0 (bubble).
  - `!stall[5]` → `mem12mem2_bus`.
  - Otherwise hold.
- **`fresh` flag:**
  - Set to 1 when `r` loads a new bus, i.e. `!stall[5]` and not in reset.
  - Cleared to 0 on reset, on bubble, and on every hold cycle.
- **Hold buffer `hbuf`[32]:**
  - Captures `data_sram_rdata` on each clk edge where `fresh=1`.
  - Otherwise holds its value. Reset value 0.
- **Raw load data:** `raw = fresh ? data_sram_rdata : hbuf`.
- **Alignment**, by `load_type`:
  - 000 LB: sign-extend `raw[8*addr_lo +: 8]`.
  - 100 LBU: zero-extend the same byte.
  - 001 LH: sign-extend `raw[16*addr_lo[1] +: 16]`; `addr_lo[0]` is ignored (misalignment is trapped upstream).
  - 101 LHU: zero-extend the same halfword.
  - 010 LW and all other codes: `raw` unmodified.
- **Result:** `wdata_out = load_en ? aligned : r.rf_wdata`.
- **Write enable:** `we_out = r.rf_we & (r.rf_waddr != 0)`. An x0 write is never reported.
- **`mem22wb_bus`** = {`we_out`, `r.rf_waddr`, `wdata_out`, `r.pc`, `r.inst`}.
- **`mem22bp_bus`** = {`we_out`, `r.rf_waddr`, `wdata_out`}.
- **Reset:** both output buses are 0 out of reset and after a bubble.

## Timing
- One register stage. Outputs are combinational from `r`, `fresh`, `hbuf` and `data_sram_rdata`; no further latency.
- SRAM contract: read data for the load in `r` is on `data_sram_rdata` only during the cycle after `r` captured it (`fresh=1`). In any later cycle the value comes from `hbuf`.
- Stall of arbitrary length with a load resident: the output data stays constant and equal to the first-cycle SRAM data, even if `data_sram_rdata` changes.
- Simultaneous `stall[5]` and `stall[6]`: hold. `fresh` drops after the first held cycle and `hbuf` holds.
- Reset asserted mid-stall: `r`, `fresh` and `hbuf` all go to 0 at the next edge. The outputs then carry `we=0`.
- Non-load instructions: `hbuf` may update but is never used, since `load_en=0`.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles → `mem22wb_bus=0`, `mem22bp_bus=0`.
- **ALU pass-through:** `rf_we=1`, `waddr=5`, `wdata=0x1234_5678`, `load_en=0`, no stall → next cycle `mem22bp_bus={1,5,0x12345678}`, with `pc`/`inst` passed through.
- **Load alignment**, with `rdata=0x80FF_7F01` returned in the fresh cycle:
  - LB `addr_lo=3` → `0xFFFF_FF80`.
  - LBU `addr_lo=1` → `0x0000_007F`.
  - LH `addr_lo=2` → `0xFFFF_80FF`.
  - LHU `addr_lo=0` → `0x0000_7F01`.
  - LW → `0x80FF_7F01`.
- **Load under stall:** LW with `rdata=0xDEAD_BEEF` in the fresh cycle, then `stall[5]=stall[6]=1` for 3 cycles while `rdata` is driven to `0x0` → output stays `0xDEAD_BEEF` throughout. After release the next instruction is presented.
- **Bubble:** `stall[5]=1`, `stall[6]=0` → next cycle `mem22wb_bus=0`. Then `stall[5]=0` → the new instruction is loaded.
- **x0 write:** `rf_we=1`, `waddr=0`, `wdata=0xFFFF_FFFF` → `we_out=0` on both buses.

Source files
------------

// File: rtl/mem2_stage.sv
// rtl/mem2_stage.sv - MEM2 pipeline stage: load capture, hold buffer, alignment, WB/bypass buses
module mem2_stage #(
  parameter int MEM12MEM2_WD = 108,
  parameter int MEM22WB_WD   = 102,
  parameter int BYPASS_WD    = 38,
  parameter int STALL_WD     = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [MEM12MEM2_WD-1:0] mem12mem2_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM22WB_WD-1:0]   mem22wb_bus,
  output logic [BYPASS_WD-1:0]    mem22bp_bus
);

  // Pipeline register, first-cycle flag and SRAM hold buffer
  logic [MEM12MEM2_WD-1:0] r_q, r_d;
  logic                    fresh_q, fresh_d;
  logic [31:0]             hbuf_q, hbuf_d;

  // Fields of the resident instruction
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_rf_wdata;
  logic        r_load_en;
  logic [2:0]  r_load_type;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  logic        stall_self;
  logic        stall_wb;
  logic [31:0] raw;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] aligned;
  logic [31:0] wdata_out;
  logic        we_out;

  // Only this stage's and WB's stall bits matter here
  logic unused_stall;
  assign unused_stall = ^stall[4:0];

  assign stall_self = stall[5];
  assign stall_wb   = stall[6];

  assign r_rf_we     = r_q[107];
  assign r_rf_waddr  = r_q[106:102];
  assign r_rf_wdata  = r_q[101:70];
  assign r_load_en   = r_q[69];
  assign r_load_type = r_q[68:66];
  assign r_addr_lo   = r_q[65:64];
  assign r_pc        = r_q[63:32];
  assign r_inst      = r_q[31:0];

  // Next state: bubble has priority over load; SRAM data is latched only in the fresh cycle
  always_comb begin
    r_d     = r_q;
    fresh_d = 1'b0;
    hbuf_d  = hbuf_q;
    if (fresh_q) begin
      hbuf_d = data_sram_rdata;
    end
    if (stall_self && !stall_wb) begin
      r_d = '0;
    end else if (!stall_self) begin
      r_d     = mem12mem2_bus;
      fresh_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= '0;
      fresh_q <= 1'b0;
      hbuf_q  <= '0;
    end else begin
      r_q     <= r_d;
      fresh_q <= fresh_d;
      hbuf_q  <= hbuf_d;
    end
  end

  assign raw = fresh_q ? data_sram_rdata : hbuf_q;

  // Byte/halfword lane selection; addr_lo[0] is ignored for halfwords
  always_comb begin
    sel_byte = raw[7:0];
    case (r_addr_lo)
      2'd0: sel_byte = raw[7:0];
      2'd1: sel_byte = raw[15:8];
      2'd2: sel_byte = raw[23:16];
      2'd3: sel_byte = raw[31:24];
      default: sel_byte = raw[7:0];
    endcase
    sel_half = r_addr_lo[1] ? raw[31:16] : raw[15:0];
  end

  // Extension by funct3; unknown codes pass the word through
  always_comb begin
    aligned = raw;
    case (r_load_type)
      3'b000:  aligned = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  aligned = {24'h0, sel_byte};
      3'b001:  aligned = {{16{sel_half[15]}}, sel_half};
      3'b101:  aligned = {16'h0, sel_half};
      default: aligned = raw;
    endcase
  end

  assign wdata_out = r_load_en ? aligned : r_rf_wdata;
  assign we_out    = r_rf_we & (r_rf_waddr != 5'd0);

  assign mem22wb_bus = {we_out, r_rf_waddr, wdata_out, r_pc, r_inst};
  assign mem22bp_bus = {we_out, r_rf_waddr, wdata_out};

endmodule
